// File: rtl/inst_set.sv
// Instruction-set constants and per-opcode decode table shared by the decode stage.
package inst_set;

  localparam logic [5:0] INST_NOP  = 6'h00;
  localparam logic [5:0] INST_ALU  = 6'h01;
  localparam logic [5:0] INST_ADDI = 6'h02;
  localparam logic [5:0] INST_ORI  = 6'h03;
  localparam logic [5:0] INST_LW   = 6'h08;
  localparam logic [5:0] INST_SW   = 6'h09;
  localparam logic [5:0] INST_J    = 6'h10;
  localparam logic [5:0] INST_JAL  = 6'h11;
  localparam logic [5:0] INST_JALR = 6'h12;
  localparam logic [5:0] INST_BEQ  = 6'h1C;
  localparam logic [5:0] INST_BNE  = 6'h1D;
  localparam logic [5:0] INST_FADD = 6'h20;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU_R  = 4'd1,
    CLS_ALU_I  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_J      = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_FPU    = 4'd9
  } inst_class_t;

  typedef struct packed {
    inst_class_t cls;
    logic        zext;
    logic        uses_rs;
    logic        uses_rt;
    logic        writes;
    logic        fp;
  } op_info_t;

  function automatic op_info_t op_info(input logic [5:0] op);
    op_info_t info;
    info     = '0;
    info.cls = CLS_NOP;
    // Branches are a whole opcode region rather than single table entries.
    if (((op[5] ^ op[4]) & op[3] & op[2]) == 1'b1) begin
      info.cls     = CLS_BRANCH;
      info.uses_rs = 1'b1;
      info.uses_rt = 1'b1;
    end else begin
      case (op)
        INST_ALU:  begin info.cls = CLS_ALU_R; info.uses_rs = 1'b1; info.uses_rt = 1'b1; info.writes = 1'b1; end
        INST_ADDI: begin info.cls = CLS_ALU_I; info.uses_rs = 1'b1; info.writes = 1'b1; end
        INST_ORI:  begin info.cls = CLS_ALU_I; info.uses_rs = 1'b1; info.writes = 1'b1; info.zext = 1'b1; end
        INST_LW:   begin info.cls = CLS_LOAD;  info.uses_rs = 1'b1; info.writes = 1'b1; end
        INST_SW:   begin info.cls = CLS_STORE; info.uses_rs = 1'b1; info.uses_rt = 1'b1; end
        INST_J:    info.cls = CLS_J;
        INST_JAL:  begin info.cls = CLS_JAL;  info.writes = 1'b1; end
        INST_JALR: begin info.cls = CLS_JALR; info.uses_rs = 1'b1; info.writes = 1'b1; end
        INST_FADD: begin info.cls = CLS_FPU;  info.uses_rs = 1'b1; info.uses_rt = 1'b1; info.writes = 1'b1; info.fp = 1'b1; end
        default:   info.cls = CLS_NOP;
      endcase
    end
    return info;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one busy bit per register id, GPR 0 hard-wired idle.
module decode_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned RID_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_en,
  input  logic [RID_W-1:0]  set_rid,
  input  logic              clr_en,
  input  logic [RID_W-1:0]  clr_rid,
  input  logic [RID_W-1:0]  q0_rid,
  input  logic [RID_W-1:0]  q1_rid,
  output logic              q0_busy,
  output logic              q1_busy,
  output logic [2*NREG-1:0] busy
);

  logic [2*NREG-1:0] busy_next;

  // Clear first so a same-cycle set of the same id survives.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_rid] = 1'b0;
    if (set_en) busy_next[set_rid] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_next;
  end

  assign q0_busy = busy[q0_rid] & ~(clr_en & (clr_rid == q0_rid));
  assign q1_busy = busy[q1_rid] & ~(clr_en & (clr_rid == q1_rid));

endmodule

// File: rtl/decode.sv
// Decode stage: field split, class/immediate decode, RAW stall and output register.
module decode
  import inst_set::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned RID_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_command,
  input  logic             wb_en,
  input  logic [RID_W-1:0] wb_rid,
  output logic             stall,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [5:0]       out_opecode,
  output logic [RID_W-1:0] out_rd,
  output logic [RID_W-1:0] out_rs,
  output logic [RID_W-1:0] out_rt,
  output logic [XLEN-1:0]  out_imm,
  output inst_class_t      out_class,
  output logic             out_we
);

  logic [5:0]       op;
  logic [4:0]       rd_idx, rs_idx, rt_idx;
  logic [15:0]      imm16;
  logic [25:0]      target26;
  op_info_t         info;
  logic [RID_W-1:0] rd_id, rs_id, rt_id;
  logic [XLEN-1:0]  imm;
  logic             rs_busy, rt_busy;
  logic             advance, set_en;
  logic             we_q;
  logic [2*NREG-1:0] busy;

  assign op       = in_command[31:26];
  assign rd_idx   = in_command[25:21];
  assign rs_idx   = in_command[20:16];
  assign rt_idx   = in_command[15:11];
  assign imm16    = in_command[15:0];
  assign target26 = in_command[25:0];
  assign info     = op_info(op);

  assign rd_id = (info.cls == CLS_JAL) ? RID_W'(31) : {info.fp, rd_idx};
  assign rs_id = {info.fp, rs_idx};
  assign rt_id = {info.fp, rt_idx};

  always_comb begin
    imm = '0;
    if (info.cls == CLS_J || info.cls == CLS_JAL) imm = XLEN'({target26, 2'b00});
    else if (info.zext)                           imm = {{(XLEN-16){1'b0}}, imm16};
    else                                          imm = {{(XLEN-16){imm16[15]}}, imm16};
  end

  decode_scoreboard #(.NREG(NREG), .RID_W(RID_W)) u_sb (
    .clk     (clk),
    .rstn    (rstn),
    .set_en  (set_en),
    .set_rid (rd_id),
    .clr_en  (wb_en),
    .clr_rid (wb_rid),
    .q0_rid  (rs_id),
    .q1_rid  (rt_id),
    .q0_busy (rs_busy),
    .q1_busy (rt_busy),
    .busy    (busy)
  );

  assign stall   = in_valid & ~flush & ((info.uses_rs & rs_busy) | (info.uses_rt & rt_busy));
  assign advance = enable & ~flush & ~stall;
  assign set_en  = advance & in_valid & info.writes;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opecode <= '0;
      out_rd      <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_imm     <= '0;
      out_class   <= CLS_NOP;
      we_q        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (enable) begin
      if (stall) begin
        out_valid <= 1'b0;
      end else begin
        out_valid   <= in_valid;
        out_pc      <= in_pc;
        out_opecode <= op;
        out_rd      <= rd_id;
        out_rs      <= rs_id;
        out_rt      <= rt_id;
        out_imm     <= imm;
        out_class   <= info.cls;
        we_q        <= info.writes;
      end
    end
  end

  assign out_we = out_valid & we_q;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage with hand-computed expectations.
module tb_decode;
  import inst_set::*;

  logic        clk, rstn, enable, flush, in_valid, wb_en;
  logic [31:0] in_pc, in_command;
  logic [5:0]  wb_rid;
  logic        stall, out_valid, out_we;
  logic [31:0] out_pc, out_imm;
  logic [5:0]  out_opecode, out_rd, out_rs, out_rt;
  inst_class_t out_class;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  decode #(.XLEN(32), .NREG(32), .RID_W(6)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_command(in_command),
    .wb_en(wb_en), .wb_rid(wb_rid), .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_opecode(out_opecode),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
    .out_class(out_class), .out_we(out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'b0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic issue(input logic [31:0] pc, input logic [31:0] cmd);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_command = cmd;
    #1;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_rid = '0;
    in_valid = 1'b1; in_pc = 32'h4; in_command = mk_r(INST_ALU, 5'd3, 5'd1, 5'd2);
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_imm", out_imm, 0);
    check("rst_rd", out_rd, 0);
    check("rst_busy", dut.u_sb.busy, 0);
    check("rst_stall", stall, 0);
    check("rst_we", out_we, 0);

    rstn = 1'b1;
    issue(32'h10, mk_r(INST_ALU, 5'd3, 5'd1, 5'd2));
    check("add_stall", stall, 0);
    tick();
    check("add_valid", out_valid, 1);
    check("add_pc", out_pc, 32'h10);
    check("add_rd", out_rd, 3);
    check("add_rs", out_rs, 1);
    check("add_rt", out_rt, 2);
    check("add_class", out_class, CLS_ALU_R);
    check("add_we", out_we, 1);
    check("add_busy3", dut.u_sb.busy[3], 1);

    issue(32'h14, mk_i(INST_LW, 5'd5, 5'd4, 16'h0008));
    tick();
    check("lw_class", out_class, CLS_LOAD);
    check("lw_imm", out_imm, 32'h8);
    check("lw_busy5", dut.u_sb.busy[5], 1);

    issue(32'h18, mk_r(INST_ALU, 5'd6, 5'd5, 5'd1));
    check("raw_stall", stall, 1);
    tick();
    check("bubble1_valid", out_valid, 0);
    check("bubble1_pc_hold", out_pc, 32'h14);
    check("bubble1_we", out_we, 0);
    tick();
    check("bubble2_valid", out_valid, 0);
    check("bubble2_busy6", dut.u_sb.busy[6], 0);
    wb_en = 1'b1; wb_rid = 6'd5;
    #1;
    check("wb_bypass_stall", stall, 0);
    tick();
    wb_en = 1'b0;
    check("raw_release_valid", out_valid, 1);
    check("raw_release_pc", out_pc, 32'h18);
    check("raw_busy5", dut.u_sb.busy[5], 0);
    check("raw_busy6", dut.u_sb.busy[6], 1);

    issue(32'h1C, mk_r(INST_BEQ, 5'd0, 5'd3, 5'd1));
    check("br_stall", stall, 1);
    wb_en = 1'b1; wb_rid = 6'd3;
    #1;
    check("br_wb_stall", stall, 0);
    tick();
    wb_en = 1'b0;
    check("br_class", out_class, CLS_BRANCH);
    check("br_we", out_we, 0);
    check("br_busy3", dut.u_sb.busy[3], 0);

    issue(32'h20, {INST_JAL, 26'h000100});
    tick();
    check("jal_imm", out_imm, 32'h00000400);
    check("jal_rd", out_rd, 31);
    check("jal_class", out_class, CLS_JAL);
    check("jal_busy31", dut.u_sb.busy[31], 1);

    issue(32'h24, mk_i(INST_ADDI, 5'd8, 5'd0, 16'h8000));
    tick();
    check("addi_sext", out_imm, 32'hFFFF8000);
    issue(32'h28, mk_i(INST_ORI, 5'd10, 5'd0, 16'h8000));
    tick();
    check("ori_zext", out_imm, 32'h00008000);
    check("ori_class", out_class, CLS_ALU_I);

    issue(32'h2C, mk_r(INST_FADD, 5'd1, 5'd2, 5'd3));
    tick();
    check("fadd_rd", out_rd, 33);
    check("fadd_rs", out_rs, 34);
    check("fadd_class", out_class, CLS_FPU);

    flush = 1'b1;
    issue(32'h30, mk_i(INST_ADDI, 5'd7, 5'd0, 16'h0001));
    check("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_we", out_we, 0);
    check("flush_busy7", dut.u_sb.busy[7], 0);

    issue(32'h34, mk_i(INST_ADDI, 5'd0, 5'd0, 16'h0001));
    tick();
    check("r0_valid", out_valid, 1);
    check("r0_busy0", dut.u_sb.busy[0], 0);
    issue(32'h38, mk_r(INST_ALU, 5'd11, 5'd0, 5'd0));
    check("r0_read_stall", stall, 0);
    tick();

    issue(32'h3C, mk_i(INST_ADDI, 5'd9, 5'd0, 16'h0002));
    tick();
    check("r9_set", dut.u_sb.busy[9], 1);
    wb_en = 1'b1; wb_rid = 6'd9;
    issue(32'h40, mk_i(INST_ADDI, 5'd9, 5'd0, 16'h0003));
    tick();
    check("r9_set_wins", dut.u_sb.busy[9], 1);
    in_valid = 1'b0; in_pc = 32'h44;
    tick();
    check("r9_cleared", dut.u_sb.busy[9], 0);
    check("idle_valid", out_valid, 0);
    wb_rid = 6'd20;
    tick();
    wb_en = 1'b0;
    check("wb_idle_busy", dut.u_sb.busy, 64'h0000_0002_8000_0D40);

    issue(32'h48, mk_i(INST_ADDI, 5'd12, 5'd0, 16'h0004));
    tick();
    enable = 1'b0;
    issue(32'h50, mk_i(INST_ADDI, 5'd13, 5'd0, 16'h0005));
    tick();
    check("hold_valid", out_valid, 1);
    check("hold_pc", out_pc, 32'h48);
    check("hold_busy13", dut.u_sb.busy[13], 0);
    enable = 1'b1;

    issue(32'h54, mk_r(INST_ALU, 5'd14, 5'd6, 5'd0));
    check("rst_mid_stall", stall, 1);
    rstn = 1'b0;
    tick();
    check("rst2_valid", out_valid, 0);
    check("rst2_pc", out_pc, 0);
    check("rst2_busy", dut.u_sb.busy, 0);
    rstn = 1'b1; in_valid = 1'b0;
    tick();
    check("rst2_dropped", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
